// File: rtl/mul_seq_pkg.sv
// rtl/mul_seq_pkg.sv - shared constants and helpers for the multiplier sequencer/arbiter
package mul_seq_pkg;

  localparam int NUM_PORTS = 2;

  localparam logic OP_MUL    = 1'b0;
  localparam logic OP_MULXUU = 1'b1;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_ISSUE1 = 3'd1;
  localparam state_t ST_WAIT1  = 3'd2;
  localparam state_t ST_ISSUE2 = 3'd3;
  localparam state_t ST_WAIT2  = 3'd4;
  localparam state_t ST_RESP   = 3'd5;

  function automatic logic [NUM_PORTS-1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mul_seq_rr_arb.sv
// rtl/mul_seq_rr_arb.sv - two-port round-robin grant with last_grant memory
module mul_seq_rr_arb
  import mul_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] req_valid,
  input  logic                 accept,
  output logic [NUM_PORTS-1:0] grant
);

  // Resets to port 1 so that port 0 wins the first tie.
  logic last_grant;

  always_comb begin
    grant = '0;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/mul_seq_arbiter.sv
// rtl/mul_seq_arbiter.sv - sequences 32x32 multiplies on a shared 16x16 partial-product cell for two requesters
module mul_seq_arbiter
  import mul_seq_pkg::*;
#(
  parameter int MUL_LATENCY = 1
)
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        req_valid,
  output logic [NUM_PORTS-1:0]        req_ready,
  input  logic [NUM_PORTS-1:0]        req_op,
  input  logic [NUM_PORTS-1:0][31:0]  req_a,
  input  logic [NUM_PORTS-1:0][31:0]  req_b,
  output logic [NUM_PORTS-1:0]        rsp_valid,
  input  logic [NUM_PORTS-1:0]        rsp_ready,
  output logic [31:0]                 rsp_data,
  output logic [31:0]                 mul_src1,
  output logic [31:0]                 mul_src2,
  output logic                        mul_en,
  input  logic [31:0]                 mul_p1,
  input  logic [31:0]                 mul_p2,
  input  logic [31:0]                 mul_p3
);

  localparam logic [1:0] WAIT_LOAD = 2'(MUL_LATENCY - 1);

  state_t               state;
  logic                 op_q;
  logic                 port_q;
  logic [1:0]           wait_cnt;
  logic [16:0]          lo_hi;
  logic [NUM_PORTS-1:0] grant;
  logic                 accept;
  logic                 rsp_fire;
  logic [32:0]          mid;
  logic [48:0]          lo64;

  mul_seq_rr_arb u_arb (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .accept    (accept),
    .grant     (grant)
  );

  assign req_ready = (state == ST_IDLE && !reset) ? grant : '0;
  assign accept    = |(req_valid & req_ready);
  assign rsp_valid = (state == ST_RESP && !reset) ? port_onehot(port_q) : '0;
  assign rsp_fire  = |(rsp_valid & rsp_ready);
  assign mul_en    = (state == ST_ISSUE1) || (state == ST_ISSUE2);

  // lo64[48:32] is the carry-out of the low word into the high-word pass.
  assign mid  = {1'b0, mul_p2} + {1'b0, mul_p3};
  assign lo64 = {17'b0, mul_p1} + {mid, 16'b0};

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      op_q     <= OP_MUL;
      port_q   <= 1'b0;
      wait_cnt <= '0;
      lo_hi    <= '0;
      rsp_data <= '0;
      mul_src1 <= '0;
      mul_src2 <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            port_q   <= grant[1];
            op_q     <= req_op[grant[1]];
            mul_src1 <= req_a[grant[1]];
            mul_src2 <= req_b[grant[1]];
            state    <= ST_ISSUE1;
          end
        end
        ST_ISSUE1: begin
          wait_cnt <= WAIT_LOAD;
          state    <= ST_WAIT1;
        end
        ST_WAIT1: begin
          if (wait_cnt != 2'd0) begin
            wait_cnt <= wait_cnt - 2'd1;
          end else begin
            lo_hi <= lo64[48:32];
            if (op_q == OP_MULXUU) begin
              // Second pass reuses the p1 lane for a_hi*b_hi.
              mul_src1 <= {16'h0, mul_src1[31:16]};
              mul_src2 <= {16'h0, mul_src2[31:16]};
              state    <= ST_ISSUE2;
            end else begin
              rsp_data <= lo64[31:0];
              state    <= ST_RESP;
            end
          end
        end
        ST_ISSUE2: begin
          wait_cnt <= WAIT_LOAD;
          state    <= ST_WAIT2;
        end
        ST_WAIT2: begin
          if (wait_cnt != 2'd0) begin
            wait_cnt <= wait_cnt - 2'd1;
          end else begin
            rsp_data <= mul_p1 + {15'b0, lo_hi};
            state    <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_fire) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_arbiter.sv
// tb/tb_mul_seq_arbiter.sv - scoreboard bench for mul_seq_arbiter with behavioural multiplier cells
module tb_mul_seq_arbiter;
  import mul_seq_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [1:0]       req_valid, req_ready, req_op, rsp_valid, rsp_ready;
  logic [1:0][31:0] req_a, req_b;
  logic [31:0]      rsp_data, mul_src1, mul_src2, mul_p1, mul_p2, mul_p3;
  logic             mul_en;

  logic [1:0]       req_valid3, req_ready3, req_op3, rsp_valid3, rsp_ready3;
  logic [1:0][31:0] req_a3, req_b3;
  logic [31:0]      rsp_data3, mul_src13, mul_src23, mul_p13, mul_p23, mul_p33;
  logic             mul_en3;

  mul_seq_arbiter #(.MUL_LATENCY(1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .mul_src1(mul_src1), .mul_src2(mul_src2), .mul_en(mul_en),
    .mul_p1(mul_p1), .mul_p2(mul_p2), .mul_p3(mul_p3)
  );

  mul_seq_arbiter #(.MUL_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid3), .req_ready(req_ready3), .req_op(req_op3),
    .req_a(req_a3), .req_b(req_b3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_data(rsp_data3),
    .mul_src1(mul_src13), .mul_src2(mul_src23), .mul_en(mul_en3),
    .mul_p1(mul_p13), .mul_p2(mul_p23), .mul_p3(mul_p33)
  );

  function automatic logic [95:0] cell_prod(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y, z;
    x = 32'(a[15:0]) * 32'(b[15:0]);
    y = 32'(a[15:0]) * 32'(b[31:16]);
    z = 32'(a[31:16]) * 32'(b[15:0]);
    return {x, y, z};
  endfunction

  function automatic logic [31:0] ref_mul(input logic op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    return op ? p[63:32] : p[31:0];
  endfunction

  // Behavioural multiplier cells: latency 1 and latency 3.
  always @(posedge clk) begin
    if (reset) {mul_p1, mul_p2, mul_p3} <= '0;
    else if (mul_en) {mul_p1, mul_p2, mul_p3} <= cell_prod(mul_src1, mul_src2);
  end

  logic [95:0] pipe3 [3];
  always @(posedge clk) begin
    if (reset) begin
      pipe3[0] <= '0; pipe3[1] <= '0; pipe3[2] <= '0;
    end else begin
      if (mul_en3) pipe3[0] <= cell_prod(mul_src13, mul_src23);
      pipe3[1] <= pipe3[0];
      pipe3[2] <= pipe3[1];
    end
  end
  assign {mul_p13, mul_p23, mul_p33} = pipe3[2];

  int n_pass = 0, n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_total++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  typedef struct {
    int          port;
    logic        op;
    logic [31:0] data;
    int          hs_cycle;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_pop, e_new;
  int   cycle = 0;
  bit   lat_done = 0;
  int   en3_cnt = 0;

  always @(posedge clk) cycle++;
  always @(negedge clk) if (mul_en3) en3_cnt++;

  // Monitor: pushes model results at request handshakes, pops at response handshakes.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      lat_done = 0;
    end else begin
      if (rsp_valid != 2'b00) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_rsp");
        end else begin
          if (!lat_done) begin
            lat_done = 1;
            check("rsp_latency", 64'(cycle - exp_q[0].hs_cycle), exp_q[0].op ? 64'd5 : 64'd3);
          end
          if ((rsp_valid & rsp_ready) != 2'b00) begin
            e_pop = exp_q.pop_front();
            check("rsp_port", 64'(rsp_valid), e_pop.port == 1 ? 64'h2 : 64'h1);
            check("rsp_data", 64'(rsp_data), 64'(e_pop.data));
            lat_done = 0;
          end
        end
      end
      if ((req_valid & req_ready) != 2'b00) begin
        check("req_ready_onehot", 64'($countones(req_ready)), 64'd1);
        e_new.port     = req_ready[1] ? 1 : 0;
        e_new.op       = req_op[e_new.port];
        e_new.data     = ref_mul(req_op[e_new.port], req_a[e_new.port], req_b[e_new.port]);
        e_new.hs_cycle = cycle;
        exp_q.push_back(e_new);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int p, input logic op, input logic [31:0] a, input logic [31:0] b);
    req_op[p] = op; req_a[p] = a; req_b[p] = b; req_valid[p] = 1'b1;
    for (int i = 0; i <= 50; i++) begin
      @(negedge clk);
      if (req_ready[p]) break;
      if (i == 50) fail_now("handshake_timeout");
    end
    tick();
    req_valid[p] = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i <= 100; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
      if (i == 100) fail_now("drain_timeout");
    end
    tick();
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 3))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000 | $urandom();
      default: return $urandom();
    endcase
  endfunction

  int          rem0, rem1, hs3, pp;
  int          order[$];
  logic [31:0] held;

  initial begin
    reset = 1'b1;
    req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 2'b11;
    req_valid3 = '0; req_op3 = '0; req_a3 = '0; req_b3 = '0; rsp_ready3 = 2'b11;
    req_valid = 2'b01;
    tick();
    @(negedge clk);
    check("reset_req_ready", 64'(req_ready), 64'h0);
    check("reset_rsp_valid", 64'(rsp_valid), 64'h0);
    check("reset_mul_en", 64'(mul_en), 64'h0);
    check("reset_mul_src1", 64'(mul_src1), 64'h0);
    check("reset_mul_src2", 64'(mul_src2), 64'h0);
    check("reset_rsp_data", 64'(rsp_data), 64'h0);
    tick();
    req_valid = '0;
    reset = 1'b0;
    tick();

    send(0, OP_MUL, 32'h0001_0003, 32'h0002_0005);
    drain();
    send(1, OP_MULXUU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    drain();
    send(1, OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    drain();

    // Both ports contend continuously after a fresh reset.
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    rem0 = 4; rem1 = 4;
    req_op = 2'b00;
    for (int i = 0; i < 200 && (rem0 > 0 || rem1 > 0); i++) begin
      req_valid = {rem1 > 0, rem0 > 0};
      req_a[0] = $urandom(); req_b[0] = $urandom();
      req_a[1] = $urandom(); req_b[1] = $urandom();
      @(negedge clk);
      if ((req_ready & req_valid) != 2'b00) begin
        pp = req_ready[1] ? 1 : 0;
        order.push_back(pp);
        if (pp == 1) rem1--; else rem0--;
      end
      tick();
    end
    req_valid = '0;
    check("grant_count", 64'(order.size()), 64'd8);
    foreach (order[i]) check("grant_order", 64'(order[i]), 64'(i % 2));
    drain();

    // Response stall on port 0 while port 1 waits.
    rsp_ready = 2'b10;
    send(0, OP_MUL, $urandom(), $urandom());
    req_op[1] = OP_MUL; req_a[1] = $urandom(); req_b[1] = $urandom(); req_valid[1] = 1'b1;
    for (int i = 0; i <= 20; i++) begin
      @(negedge clk);
      if (rsp_valid[0]) break;
      if (i == 20) fail_now("stall_rsp_timeout");
    end
    held = rsp_data;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("stall_rsp_data", 64'(rsp_data), 64'(held));
      check("stall_rsp_valid", 64'(rsp_valid), 64'h1);
      check("stall_mul_en", 64'(mul_en), 64'h0);
      check("stall_req_ready", 64'(req_ready), 64'h0);
    end
    tick();
    rsp_ready = 2'b11;
    @(negedge clk);
    tick();
    @(negedge clk);
    check("post_stall_grant", 64'(req_ready), 64'h2);
    tick();
    req_valid[1] = 1'b0;
    drain();

    // Reset while in WAIT2 aborts the transaction.
    send(0, OP_MULXUU, rand_operand() | 32'h1, rand_operand() | 32'h1);
    tick(); tick(); tick();
    reset = 1'b1;
    req_valid[0] = 1'b1;
    tick();
    @(negedge clk);
    check("abort_rsp_valid", 64'(rsp_valid), 64'h0);
    check("abort_req_ready", 64'(req_ready), 64'h0);
    check("abort_mul_en", 64'(mul_en), 64'h0);
    check("abort_mul_src1", 64'(mul_src1), 64'h0);
    check("abort_mul_src2", 64'(mul_src2), 64'h0);
    check("abort_rsp_data", 64'(rsp_data), 64'h0);
    tick();
    req_valid[0] = 1'b0;
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("abort_no_rsp", 64'(rsp_valid), 64'h0);
    end
    tick();
    send(0, OP_MUL, $urandom(), $urandom());
    drain();

    // Randomized traffic with corner operands.
    for (int t = 0; t < 24; t++) begin
      repeat ($urandom_range(0, 2)) tick();
      send(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_operand(), rand_operand());
      drain();
    end

    // MUL_LATENCY = 3 instance.
    en3_cnt = 0;
    req_op3[0] = OP_MULXUU; req_a3[0] = 32'h8000_0000; req_b3[0] = 32'h0000_0002;
    req_valid3[0] = 1'b1;
    hs3 = 0;
    for (int i = 0; i <= 20; i++) begin
      @(negedge clk);
      if (req_ready3[0]) begin hs3 = cycle; break; end
      if (i == 20) fail_now("lat3_handshake_timeout");
    end
    tick();
    req_valid3[0] = 1'b0;
    for (int i = 0; i <= 30; i++) begin
      @(negedge clk);
      if (rsp_valid3 != 2'b00) break;
      if (i == 30) fail_now("lat3_rsp_timeout");
    end
    check("lat3_cycle", 64'(cycle - hs3), 64'd9);
    check("lat3_port", 64'(rsp_valid3), 64'h1);
    check("lat3_data", 64'(rsp_data3), 64'(ref_mul(OP_MULXUU, 32'h8000_0000, 32'h0000_0002)));
    repeat (4) tick();
    check("lat3_mul_en_cycles", 64'(en3_cnt), 64'd2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
